// File: rtl/m_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// m_cordic_iter_ctrl
//
// Iterative CORDIC rotator. One add/shift rotation stage is reused STAGES
// times under a small FSM. This trades throughput for area compared with an
// unrolled pipeline. A vector (x, y, z) plus a sideband flag is taken on a
// valid/ready input port. The shift amount and the arctangent constant are
// stepped once per iteration. The rotated vector is returned on a valid/ready
// output port.
//
// The rotation gain (~1.6468) is not compensated. Add/sub wrap without
// saturation, so the caller must leave about 0.7 bit of headroom.
//
// Parameters
//   bitwidth  width of the x/y datapath (two's complement)
//   zwidth    width of angle z; 2^zwidth = 360 degrees
//   STAGES    rotations per vector (2..16); iteration i shifts by i
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   enable     0 freezes FSM, counter, data and outputs
//   in_valid   input vector valid
//   in_ready   block can accept (IDLE only)
//   xi, yi     input vector
//   zi         input angle
//   flag_in    sideband bit carried with the vector
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts the result
//   xo, yo     rotated vector
//   zo         residual angle
//   flag_out   flag_in of the same vector
//   busy       FSM not in IDLE
// -----------------------------------------------------------------------------
module m_cordic_iter_ctrl #(
   parameter int bitwidth = 16,
   parameter int zwidth   = 16,
   parameter int STAGES   = 12
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [bitwidth-1:0] xi,
   input  logic [bitwidth-1:0] yi,
   input  logic [zwidth-1:0]   zi,
   input  logic                flag_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [bitwidth-1:0] xo,
   output logic [bitwidth-1:0] yo,
   output logic [zwidth-1:0]   zo,
   output logic                flag_out,
   output logic                busy
);

   // Iteration counter width. The arctangent table is padded to a power of
   // two so that any counter value is a legal index.
   localparam int IW = ($clog2(STAGES) < 1) ? 1 : $clog2(STAGES);
   localparam int TAB = 1 << IW;
   localparam logic [IW-1:0] LAST_ITER = IW'(STAGES - 1);

   // The arctangent constants are held at 2^32 = 360 degrees. They are then
   // rescaled to zwidth: round-to-nearest when narrowing, and a plain left
   // shift when widening.
   localparam int ATAN_DN = (zwidth < 32) ? (32 - zwidth) : 0;
   localparam int ATAN_UP = (zwidth > 32) ? (zwidth - 32) : 0;
   localparam logic [63:0] ATAN_RND = (64'd1 << ATAN_DN) >> 1;

   function automatic logic [zwidth-1:0] atan_const(input int idx);
      logic [63:0] base;
      case (idx)
         0:       base = 64'h2000_0000;
         1:       base = 64'h12E4_051E;
         2:       base = 64'h09FB_385B;
         3:       base = 64'h0511_11D4;
         4:       base = 64'h028B_0D43;
         5:       base = 64'h0145_D7E1;
         6:       base = 64'h00A2_F61E;
         7:       base = 64'h0051_7C55;
         8:       base = 64'h0028_BE53;
         9:       base = 64'h0014_5F2F;
         10:      base = 64'h000A_2F98;
         11:      base = 64'h0005_17CC;
         12:      base = 64'h0002_8BE6;
         13:      base = 64'h0001_45F3;
         14:      base = 64'h0000_A2FA;
         15:      base = 64'h0000_517D;
         default: base = 64'h0;
      endcase
      return zwidth'(((base + ATAN_RND) >> ATAN_DN) << ATAN_UP);
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state_reg, state_next;
   logic [IW-1:0]              iter_reg, iter_next;
   logic signed [bitwidth-1:0] x_reg, x_next;
   logic signed [bitwidth-1:0] y_reg, y_next;
   logic [zwidth-1:0]          z_reg, z_next;
   logic                       flag_reg, flag_next;

   logic [zwidth-1:0]          atan_tab [0:TAB-1];
   logic [zwidth-1:0]          atan_cur;
   logic signed [bitwidth-1:0] x_shift, y_shift;
   logic                       z_pos;
   logic                       load_vec;
   logic                       rotate;

   genvar gi;
   generate
      for (gi = 0; gi < TAB; gi++) begin : g_atan
         assign atan_tab[gi] = atan_const(gi);
      end
   endgenerate

   // Shared rotation stage, steered by the iteration counter.
   assign x_shift  = x_reg >>> iter_reg;
   assign y_shift  = y_reg >>> iter_reg;
   assign atan_cur = atan_tab[iter_reg];
   assign z_pos    = ~z_reg[zwidth-1];

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         iter_reg  <= '0;
      end else begin
         state_reg <= state_next;
         iter_reg  <= iter_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state, iteration counter, handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      iter_next  = iter_reg;
      load_vec   = 1'b0;
      rotate     = 1'b0;
      in_ready   = (state_reg == IDLE);
      out_valid  = (state_reg == DONE);
      busy       = (state_reg != IDLE);

      // With enable low nothing moves; the handshake outputs simply keep
      // reflecting the frozen state.
      if (enable) begin
         unique case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  load_vec   = 1'b1;
                  iter_next  = '0;
                  state_next = RUN;
               end
            end
            RUN: begin
               rotate = 1'b1;
               if (iter_reg == LAST_ITER) begin
                  iter_next  = '0;
                  state_next = DONE;
               end else begin
                  iter_next = iter_reg + IW'(1);
               end
            end
            DONE: begin
               // The input port stays closed this edge even if in_valid is
               // high; the next vector is taken from IDLE one edge later.
               if (out_ready) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Datapath next values: load on acceptance, rotate once per RUN edge.
   // Both x and y updates use the pre-edge x_reg/y_reg.
   // ---------------------------------------------------------------------
   always_comb begin
      x_next    = x_reg;
      y_next    = y_reg;
      z_next    = z_reg;
      flag_next = flag_reg;
      if (load_vec) begin
         x_next    = xi;
         y_next    = yi;
         z_next    = zi;
         flag_next = flag_in;
      end else if (rotate) begin
         if (z_pos) begin
            x_next = x_reg - y_shift;
            y_next = y_reg + x_shift;
            z_next = z_reg - atan_cur;
         end else begin
            x_next = x_reg + y_shift;
            y_next = y_reg - x_shift;
            z_next = z_reg + atan_cur;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_reg    <= '0;
         y_reg    <= '0;
         z_reg    <= '0;
         flag_reg <= 1'b0;
      end else begin
         x_reg    <= x_next;
         y_reg    <= y_next;
         z_reg    <= z_next;
         flag_reg <= flag_next;
      end
   end

   // The working registers are the result registers.
   assign xo       = x_reg;
   assign yo       = y_reg;
   assign zo       = z_reg;
   assign flag_out = flag_reg;

endmodule

// File: tb/tb_m_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_m_cordic_iter_ctrl
//
// Directed bench for the iterative CORDIC rotator (16/16/12 configuration).
// Expected results for the 45 and -90 degree vectors were worked out by hand
// iteration by iteration. Random vectors are compared against a small
// behavioural model that uses 16-bit wrapping integers.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_m_cordic_iter_ctrl;

   localparam int BW = 16;
   localparam int ZW = 16;
   localparam int ST = 12;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          enable;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] xi, yi;
   logic [ZW-1:0] zi;
   logic          flag_in;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] xo, yo;
   logic [ZW-1:0] zo;
   logic          flag_out;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   shortint atan_t [0:15] = '{16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
                              16'sd651,  16'sd326,  16'sd163,  16'sd81,
                              16'sd41,   16'sd20,   16'sd10,   16'sd5,
                              16'sd3,    16'sd1,    16'sd1,    16'sd0};

   m_cordic_iter_ctrl #(.bitwidth(BW), .zwidth(ZW), .STAGES(ST)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .xi       (xi),
      .yi       (yi),
      .zi       (zi),
      .flag_in  (flag_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .xo       (xo),
      .yo       (yo),
      .zo       (zo),
      .flag_out (flag_out),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural reference: 16-bit wrapping arithmetic, floor shifts.
   function automatic void ref_rot(input logic [15:0] x0, input logic [15:0] y0,
                                   input logic [15:0] z0, output logic [15:0] xr,
                                   output logic [15:0] yr, output logic [15:0] zr);
      shortint x, y, z, tx;
      x = x0;
      y = y0;
      z = z0;
      for (int i = 0; i < ST; i++) begin
         if (z < 0) begin
            tx = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + atan_t[i];
         end else begin
            tx = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - atan_t[i];
         end
         x = tx;
      end
      xr = x;
      yr = y;
      zr = z;
   endfunction

   // Present a vector for one rising edge. Starts and ends just after a
   // falling edge.
   task automatic send_vec(input int x, input int y, input int z, input logic f);
      xi       = 16'(x);
      yi       = 16'(y);
      zi       = 16'(z);
      flag_in  = f;
      in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // Count rising edges until out_valid is seen, giving up after budget.
   task automatic wait_valid(input int budget, output int edges, output bit to);
      edges = 0;
      to    = 1'b0;
      while (!out_valid) begin
         if (edges >= budget) begin
            to = 1'b1;
            return;
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      total++; if (xo !== 16'd0) begin bad++; $display("FAIL reset_xo: got %h want 0000", xo); end
      total++; if (yo !== 16'd0) begin bad++; $display("FAIL reset_yo: got %h want 0000", yo); end
      total++; if (zo !== 16'd0) begin bad++; $display("FAIL reset_zo: got %h want 0000", zo); end
      total++; if (flag_out !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", flag_out); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clock);
      reset_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_after: got %b want 0", busy); end
      $display("reset: done");
   endtask

   task automatic test_rotate45();
      int  n;
      bit  to;
      out_ready = 1'b0;
      send_vec(10000, 0, 8192, 1'b1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL r45_busy: got %b want 1", busy); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL r45_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL r45_out_valid_early: got %b want 0", out_valid); end
      wait_valid(40, n, to);
      total++; if (to || n != 12) begin bad++; $display("FAIL r45_latency: got %0d (timeout %0d) want 12", n, to); end
      total++; if (xo !== 16'd11644) begin bad++; $display("FAIL r45_xo: got %0d want 11644", $signed(xo)); end
      total++; if (yo !== 16'd11646) begin bad++; $display("FAIL r45_yo: got %0d want 11646", $signed(yo)); end
      total++; if (zo !== 16'hFFFF) begin bad++; $display("FAIL r45_zo: got %0d want -1", $signed(zo)); end
      total++; if (flag_out !== 1'b1) begin bad++; $display("FAIL r45_flag: got %b want 1", flag_out); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL r45_idle: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
      total++; if (xo !== 16'd11644) begin bad++; $display("FAIL r45_xo_idle_hold: got %0d want 11644", $signed(xo)); end
      $display("rotate45: x=%0d y=%0d z=%0d latency=%0d", $signed(xo), $signed(yo), $signed(zo), n);
   endtask

   task automatic test_hold();
      int n;
      bit to;
      out_ready = 1'b0;
      send_vec(10000, 0, 8192, 1'b0);
      wait_valid(40, n, to);
      total++; if (to) begin bad++; $display("FAIL hold_timeout: got no out_valid after %0d edges want 12", n); end
      for (int k = 0; k < 5; k++) begin
         step();
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
             xo !== 16'd11644 || yo !== 16'd11646 || zo !== 16'hFFFF || flag_out !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle%0d: ov=%b ir=%b busy=%b x=%0d y=%0d z=%0d f=%b want 1 0 1 11644 11646 -1 0",
                     k, out_valid, in_ready, busy, $signed(xo), $signed(yo), $signed(zo), flag_out);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL hold_release: in_ready=%b busy=%b want 1 0", in_ready, busy); end
      $display("hold: 5 stalled cycles checked");
   endtask

   task automatic test_back_to_back();
      int acc [3];
      int na = 0;
      bit seen = 1'b0;
      int n;
      bit to;
      xi = 16'd10000; yi = 16'd0; zi = 16'd8192; flag_in = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && na < 3; k++) begin
         if (in_ready) begin
            acc[na] = cyc + 1;
            na++;
         end
         if (out_valid && !seen) begin
            seen = 1'b1;
            total++; if (xo !== 16'd11644 || yo !== 16'd11646)
               begin bad++; $display("FAIL b2b_result: got %0d,%0d want 11644,11646", $signed(xo), $signed(yo)); end
         end
         step();
      end
      in_valid = 1'b0;
      total++; if (na != 3) begin bad++; $display("FAIL b2b_count: got %0d accepts want 3", na); end
      if (na == 3) begin
         total++; if (acc[1] - acc[0] != 14) begin bad++; $display("FAIL b2b_gap1: got %0d want 14", acc[1] - acc[0]); end
         total++; if (acc[2] - acc[1] != 14) begin bad++; $display("FAIL b2b_gap2: got %0d want 14", acc[2] - acc[1]); end
      end
      wait_valid(40, n, to);
      total++; if (to) begin bad++; $display("FAIL b2b_drain: no out_valid within %0d edges want <=12", n); end
      step();
      out_ready = 1'b0;
      $display("back_to_back: accepts=%0d gaps=%0d,%0d", na, acc[1] - acc[0], acc[2] - acc[1]);
   endtask

   task automatic test_async_reset();
      int n;
      bit to;
      out_ready = 1'b0;
      send_vec(10000, 0, 8192, 1'b1);
      for (int k = 0; k < 6; k++) step();
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (xo !== 16'd0 || yo !== 16'd0 || zo !== 16'd0 || flag_out !== 1'b0)
         begin bad++; $display("FAIL areset_data: x=%h y=%h z=%h f=%b want 0", xo, yo, zo, flag_out); end
      total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL areset_ctrl: ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready); end
      @(negedge clock);
      reset_n = 1'b1;
      step();
      send_vec(-10000, 0, -16384, 1'b0);
      wait_valid(40, n, to);
      total++; if (to || n != 12) begin bad++; $display("FAIL areset_latency: got %0d (timeout %0d) want 12", n, to); end
      total++; if (xo !== 16'd5) begin bad++; $display("FAIL areset_xo: got %0d want 5", $signed(xo)); end
      total++; if (yo !== 16'd16471) begin bad++; $display("FAIL areset_yo: got %0d want 16471", $signed(yo)); end
      total++; if (zo !== 16'd3) begin bad++; $display("FAIL areset_zo: got %0d want 3", $signed(zo)); end
      total++; if (flag_out !== 1'b0) begin bad++; $display("FAIL areset_flag: got %b want 0", flag_out); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      $display("async_reset: next vector x=%0d y=%0d z=%0d", $signed(xo), $signed(yo), $signed(zo));
   endtask

   task automatic test_enable();
      int n;
      bit to;
      out_ready = 1'b0;
      send_vec(10000, 0, 8192, 1'b1);
      for (int k = 0; k < 3; k++) step();
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (xo !== 16'd8750 || yo !== 16'd13750 || zo !== 16'(-2281) || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL en_freeze%0d: x=%0d y=%0d z=%0d busy=%b ov=%b want 8750 13750 -2281 1 0",
                     k, $signed(xo), $signed(yo), $signed(zo), busy, out_valid);
         end
      end
      enable = 1'b1;
      wait_valid(40, n, to);
      total++; if (to || n != 9) begin bad++; $display("FAIL en_latency: got %0d (timeout %0d) want 9 more (15 total)", n, to); end
      total++; if (xo !== 16'd11644 || yo !== 16'd11646 || zo !== 16'hFFFF || flag_out !== 1'b1)
         begin bad++; $display("FAIL en_result: x=%0d y=%0d z=%0d f=%b want 11644 11646 -1 1", $signed(xo), $signed(yo), $signed(zo), flag_out); end
      // Frozen in DONE: out_ready must be ignored.
      enable    = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin bad++; $display("FAIL en_done_freeze%0d: ov=%b ir=%b want 1 0", k, out_valid, in_ready); end
      end
      enable = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin bad++; $display("FAIL en_done_release: ir=%b ov=%b want 1 0", in_ready, out_valid); end
      // Frozen in IDLE: in_valid must be ignored.
      enable   = 1'b0;
      xi = 16'd1234; yi = 16'd0; zi = 16'd0; flag_in = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) step();
      total++; if (busy !== 1'b0 || in_ready !== 1'b1 || xo !== 16'd11644)
         begin bad++; $display("FAIL en_idle_freeze: busy=%b ir=%b x=%0d want 0 1 11644", busy, in_ready, $signed(xo)); end
      in_valid = 1'b0;
      enable   = 1'b1;
      step();
      $display("enable: latency after freeze=%0d", 6 + n);
   endtask

   task automatic test_random();
      int n;
      bit to;
      int x, y, z;
      logic f;
      logic [15:0] ex, ey, ez;
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         x = int'($urandom_range(24000, 0)) - 12000;
         y = int'($urandom_range(24000, 0)) - 12000;
         z = int'($urandom_range(65535, 0));
         f = 1'($urandom_range(1, 0));
         ref_rot(16'(x), 16'(y), 16'(z), ex, ey, ez);
         send_vec(x, y, z, f);
         wait_valid(40, n, to);
         total++;
         if (to || {xo, yo, zo, flag_out} !== {ex, ey, ez, f}) begin
            bad++;
            $display("FAIL rand%0d: got x=%0d y=%0d z=%0d f=%b to=%0d want x=%0d y=%0d z=%0d f=%b",
                     k, $signed(xo), $signed(yo), $signed(zo), flag_out, to,
                     $signed(ex), $signed(ey), $signed(ez), f);
         end else begin
            $display("rand%0d: in=(%0d,%0d,%0d) out=(%0d,%0d,%0d)", k, x, y, z,
                     $signed(xo), $signed(yo), $signed(zo));
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   initial begin
      enable    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      xi        = '0;
      yi        = '0;
      zi        = '0;
      flag_in   = 1'b0;
      #2;
      test_reset();
      test_rotate45();
      test_hold();
      test_back_to_back();
      test_async_reset();
      test_enable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
